// File: rtl/mem_phase_ctrl_pkg.sv
// Shared types and constants for the fetch/data phase sequencer.
//   phase_e   : sequencer phase encoding (FETCH, DATA, HALT)
//   F3_*      : memory access size/sign codes carried on funct3
//   NOP_INSTR : instruction register contents after reset (add x0,x0,x0)
package mem_phase_ctrl_pkg;

  typedef enum logic [1:0] {
    PH_FETCH = 2'd0,
    PH_DATA  = 2'd1,
    PH_HALT  = 2'd2
  } phase_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0033;

endpackage

// File: rtl/mem_phase_ctrl_if.sv
// Bus between the phase sequencer and the unified byte-addressed memory.
//   s_clk           : phase select, 1 = instruction fetch, 0 = data access
//   mem_addr        : byte address
//   mem_read        : load strobe
//   mem_write       : store strobe (commits on the edge ending the cycle)
//   mem_funct3      : access size/sign
//   mem_wdata       : store data
//   mem_instruction : instruction word returned by memory
//   mem_data_out    : load data returned by memory
// master = sequencer side, slave = memory side.
interface mem_phase_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);

  logic              s_clk;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [2:0]        mem_funct3;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_instruction;
  logic [31:0]       mem_data_out;

  modport master (
    output s_clk, mem_addr, mem_read, mem_write, mem_funct3, mem_wdata,
    input  mem_instruction, mem_data_out
  );

  modport slave (
    input  s_clk, mem_addr, mem_read, mem_write, mem_funct3, mem_wdata,
    output mem_instruction, mem_data_out
  );

endinterface

// File: rtl/mem_align_chk.sv
// Combinational natural-alignment check for a data access.
//   en         : a data phase is active
//   rd, wr     : load / store requested
//   size       : funct3[1:0] (00 byte, 01 half, 10 word)
//   addr_lo    : low two bits of the byte address
//   misaligned : access requested and address not aligned to its size
module mem_align_chk
  import mem_phase_ctrl_pkg::*;
(
  input  logic       en,
  input  logic       rd,
  input  logic       wr,
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic       misaligned
);

  logic bad_addr;

  // Bytes never misalign; size code 11 is not a legal access and is let through.
  always_comb begin
    bad_addr = 1'b0;
    if (size == F3_W[1:0]) begin
      bad_addr = (addr_lo != 2'b00);
    end else if (size == F3_H[1:0]) begin
      bad_addr = addr_lo[0];
    end
  end

  assign misaligned = en & (rd | wr) & bad_addr;

endmodule

// File: rtl/mem_phase_ctrl.sv
// Two-phase sequencer between the core datapath and unified memory.
// Each instruction takes a FETCH cycle (IR loaded from memory at pc) and a
// DATA cycle (load/store on behalf of the core, PC advance). An ecall seen
// in DATA parks the sequencer in HALT until reset.
//   clk, rst        : clock, synchronous active-high reset
//   pc              : core PC (only the low ADDR_W bits address memory)
//   halt            : ecall decoded in the current IR
//   core_*          : data access request from the core
//   mem             : memory bus (master side)
//   ir, ir_valid    : latched instruction and its valid flag
//   load_data       : latched load result
//   pc_en           : core PC update enable
//   misaligned      : current DATA access is misaligned (combinational)
//   misalign_err    : sticky misalignment flag
//   halted          : sequencer is in HALT
module mem_phase_ctrl
  import mem_phase_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter logic [31:0] NOP    = NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc,
  input  logic              halt,
  input  logic              core_mem_read,
  input  logic              core_mem_write,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [2:0]        core_funct3,
  input  logic [31:0]       core_wdata,
  mem_phase_ctrl_if.master  mem,
  output logic [31:0]       ir,
  output logic              ir_valid,
  output logic [31:0]       load_data,
  output logic              pc_en,
  output logic              misaligned,
  output logic              misalign_err,
  output logic              halted
);

  localparam logic [1:0] ST_FETCH = PH_FETCH;
  localparam logic [1:0] ST_DATA  = PH_DATA;
  localparam logic [1:0] ST_HALT  = PH_HALT;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              in_data;
  logic              s_clk_c;
  logic [ADDR_W-1:0] addr_c;
  logic              read_c;
  logic              write_c;
  logic [2:0]        funct3_c;
  logic              pc_en_c;

  logic unused_pc_hi;
  assign unused_pc_hi = ^pc[31:ADDR_W];

  assign in_data = (state == ST_DATA);

  mem_align_chk u_align (
    .en         (in_data),
    .rd         (core_mem_read),
    .wr         (core_mem_write),
    .size       (core_funct3[1:0]),
    .addr_lo    (core_addr[1:0]),
    .misaligned (misaligned)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-phase memory/core controls.
  always_comb begin
    state_nxt = state;
    s_clk_c   = 1'b0;
    addr_c    = core_addr;
    read_c    = 1'b0;
    write_c   = 1'b0;
    funct3_c  = core_funct3;
    pc_en_c   = 1'b0;
    case (state)
      ST_FETCH: begin
        s_clk_c   = 1'b1;
        addr_c    = pc[ADDR_W-1:0];
        funct3_c  = F3_W;
        state_nxt = ST_DATA;
      end
      ST_DATA: begin
        // Store wins over a simultaneous load; reset drops a pending store.
        read_c    = core_mem_read & ~core_mem_write & ~misaligned;
        write_c   = core_mem_write & ~misaligned & ~rst;
        pc_en_c   = ~halt & ~rst;
        state_nxt = halt ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt = ST_FETCH;
      end
    endcase
  end

  // Instruction, load and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir           <= NOP;
      ir_valid     <= 1'b0;
      load_data    <= 32'h0;
      misalign_err <= 1'b0;
      halted       <= 1'b0;
    end else begin
      if (state == ST_FETCH) begin
        ir       <= mem.mem_instruction;
        ir_valid <= 1'b1;
      end
      if (read_c) begin
        load_data <= mem.mem_data_out;
      end
      if (misaligned) begin
        misalign_err <= 1'b1;
      end
      halted <= (state_nxt == ST_HALT);
    end
  end

  assign mem.s_clk      = s_clk_c;
  assign mem.mem_addr   = addr_c;
  assign mem.mem_read   = read_c;
  assign mem.mem_write  = write_c;
  assign mem.mem_funct3 = funct3_c;
  assign mem.mem_wdata  = core_wdata;
  assign pc_en          = pc_en_c;

endmodule
